fft_frame_counter: RTL
======================

FFT_FRAME_COUNTER -- requirements
Module: fft_frame_counter

Interface
REQ-001 Parameter N_POINTS, default 2048, meaning FFT frame length in samples, power of two, 8..65536.
REQ-002 Parameter FRAME_W, default 16, meaning width of the completed-frame counter.
REQ-003 Parameter AUTO_REARM, default 1, meaning 1 = continuous frames after one sync, 0 = single frame per sync.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 fft_sync  input  1  start-of-frame strobe from the FFT core.
REQ-008 clr_cnt  input  1  synchronous clear of all counters and state.
REQ-009 sample_valid  input  1  one FFT output sample presented this cycle.
REQ-010 count  output  CNT_W = $clog2(N_POINTS)  bin index of the next valid sample.
REQ-011 frame_cnt  output  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W.
REQ-012 counting  output  1  high while in state COUNT.
REQ-013 last_sample  output  1  combinational: counting && count == N_POINTS-1.
REQ-014 frame_done  output  1  registered one-cycle pulse after the last sample of a frame.
REQ-015 sync_err  output  1  sticky resync-mid-frame flag (present only under REQ-030).

Function
REQ-016 FSM states: IDLE, COUNT.
REQ-017 IDLE: count held at 0; fft_sync=1 at edge t SHALL give state COUNT, count=0 at t+1.
REQ-018 COUNT: each edge with sample_valid=1 SHALL increment count by 1; sample_valid=0 SHALL hold count.
REQ-019 Wrap: sample_valid=1 with count==N_POINTS-1 SHALL set count=0, frame_cnt+1, and frame_done=1 for exactly the next cycle.
REQ-020 On wrap, AUTO_REARM=1 SHALL stay in COUNT; AUTO_REARM=0 SHALL go to IDLE.
REQ-021 fft_sync=1 in COUNT SHALL restart: count=0 next cycle, frame_cnt unchanged, no frame_done, sample_valid in the same cycle ignored.
REQ-022 fft_sync coinciding with a wrap SHALL still produce the wrap's frame_done and frame_cnt increment; count=0.
REQ-023 clr_cnt=1 SHALL have highest priority: next cycle IDLE, count=0, frame_cnt=0, frame_done=0, sync_err=0, regardless of fft_sync/sample_valid.
REQ-024 frame_cnt all-ones plus one SHALL wrap to 0 with no flag.
REQ-025 Latency: count/frame_cnt/frame_done reflect inputs one edge later; last_sample has zero latency.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, count=0, frame_cnt=0, frame_done=0, sync_err=0.
REQ-027 rst_n deassertion mid-frame SHALL require a new fft_sync to resume counting.
REQ-028 counting and last_sample SHALL be 0 during and immediately after reset.

Configuration
REQ-029 Macro FFT_CNT_SYNC_ERR_EN selects resync-error detection.
REQ-030 With FFT_CNT_SYNC_ERR_EN defined: fft_sync in COUNT with count!=0 SHALL set sync_err next cycle, held until clr_cnt or reset.
REQ-031 Without it: sync_err port absent, no related logic; all other behaviour identical.

Structure
REQ-032 Package fft_cnt_pkg SHALL hold the FSM state enum (IDLE, COUNT) and default constants FFT_N_POINTS_DEF=2048, FFT_FRAME_W_DEF=16.
REQ-033 Sub-module fft_bin_counter SHALL implement the CNT_W-bit enable/clear/wrap counter with a terminal-count output; FSM and frame logic stay in the top.

Verification
REQ-034 Reset, one fft_sync, sample_valid=1 for 2048 cycles (default params) -> count 0..2047, last_sample at 2047, frame_done one cycle after, frame_cnt=1, count=0.
REQ-035 AUTO_REARM=0, N_POINTS=8, one sync, 20 valid cycles -> exactly one frame_done, counting low after cycle 8, count stays 0.
REQ-036 N_POINTS=8, sample_valid alternating 1/0 -> frame_done after 16 cycles, count holds on invalid cycles.
REQ-037 fft_sync at count=5 with macro on -> count=0 next cycle, sync_err=1 sticky, frame_cnt unchanged; clr_cnt clears it.
REQ-038 clr_cnt and fft_sync same cycle mid-frame -> state IDLE, all outputs 0; rst_n pulsed mid-frame -> same, no counting until next sync.
REQ-039 FRAME_W=2, N_POINTS=8, 5 frames continuous -> frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fft_cnt_pkg.sv
// rtl/fft_cnt_pkg.sv - shared FSM state type and default sizing for the FFT frame counter.
package fft_cnt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } fft_cnt_state_t;

  localparam int FFT_N_POINTS_DEF = 2048;
  localparam int FFT_FRAME_W_DEF  = 16;

endpackage

// File: rtl/fft_bin_counter.sv
// rtl/fft_bin_counter.sv - CNT_W-bit bin counter with enable, synchronous clear and terminal count.
module fft_bin_counter #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  // Frame length is a power of two, so the natural binary rollover is the frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == {CNT_W{1'b1}});

endmodule

// File: rtl/fft_frame_counter.sv
// rtl/fft_frame_counter.sv - FFT output bin/frame counter; FFT_CNT_SYNC_ERR_EN adds sticky resync-error flag.
module fft_frame_counter
  import fft_cnt_pkg::*;
#(
  parameter int N_POINTS   = FFT_N_POINTS_DEF,
  parameter int FRAME_W    = FFT_FRAME_W_DEF,
  parameter int AUTO_REARM = 1,
  localparam int CNT_W     = $clog2(N_POINTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fft_sync,
  input  logic               clr_cnt,
  input  logic               sample_valid,
  output logic [CNT_W-1:0]   count,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               counting,
  output logic               last_sample,
  output logic               frame_done
`ifdef FFT_CNT_SYNC_ERR_EN
  ,
  output logic               sync_err
`endif
);

  fft_cnt_state_t state, state_nxt;
  logic tc;
  logic wrap;

  assign counting    = (state == COUNT);
  assign last_sample = counting && tc;
  // A sync coinciding with the last sample still completes that frame.
  assign wrap        = counting && sample_valid && tc;

  fft_bin_counter #(
    .CNT_W(CNT_W)
  ) u_bin (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_cnt || fft_sync),
    .en   (counting && sample_valid),
    .count(count),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr_cnt) begin
      state_nxt = IDLE;
    end else if (fft_sync) begin
      state_nxt = COUNT;
    end else if (wrap && (AUTO_REARM == 0)) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (clr_cnt) begin
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (wrap) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

`ifdef FFT_CNT_SYNC_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else if (clr_cnt) begin
      sync_err <= 1'b0;
    end else if (counting && fft_sync && (count != '0)) begin
      sync_err <= 1'b1;
    end
  end
`endif

endmodule
